// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and
// hands them to the decoder through a one-entry valid/ready register.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StFetch, StWait, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        issue;

  // A new fetch may only start when the output slot is free or draining this cycle.
  always_comb begin
    issue     = (state_q == StFetch) && (!instr_valid_q || instr_ready);
    imem_req  = !rst && (issue || (state_q != StFetch));
    imem_addr = (state_q == StFetch) ? pc_q : req_addr_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (instr_valid_q && instr_ready) begin
      instr_valid_d = 1'b0;
    end
    if (issue) begin
      req_addr_d = pc_q;
    end

    if (redirect_valid) begin
      pc_d          = redirect_pc & ~32'h3;
      instr_valid_d = 1'b0;
      // An unacked request must still be drained from memory and its data dropped.
      state_d       = (imem_req && !imem_ack) ? StKill : StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (issue) begin
            if (imem_ack) begin
              instr_d       = imem_rdata;
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
              pc_d          = pc_q + 32'd4;
            end else begin
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_pc_d    = req_addr_q;
            instr_valid_d = 1'b1;
            pc_d          = req_addr_q + 32'd4;
            state_d       = StFetch;
          end
        end
        StKill: begin
          if (imem_ack) begin
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      req_addr_q    <= 32'h0;
      instr_q       <= Nop;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios with literal expectations,
// then random ready/redirect/latency traffic checked against a stream-level model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory contents: a bijective function of the word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Memory model: latency chosen when a request first appears, combinational ack.
  bit mem_busy  = 1'b0;
  int mem_left  = 0;
  int force_lat = 0;

  task automatic mem_step();
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
      if (mem_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_left--;
      end
    end else begin
      imem_ack   = ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    mem_step();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_ack       = 1'b0;
    mem_busy       = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  // Stream-level model: delivered words must follow the architectural PC sequence.
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] p_instr = 32'h0;
  logic [31:0] p_pc = 32'h0;
  logic [31:0] p_addr = 32'h0;
  bit          p_redir = 1'b0;
  bit          p_hold = 1'b0;
  bit          p_pend = 1'b0;
  int          stall = 0;
  int          delivered = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, 32'h0);
      exp_pc  = RESET_PC;
      p_redir = 1'b0;
      p_hold  = 1'b0;
      p_pend  = 1'b0;
      stall   = 0;
    end else begin
      if (p_redir) begin
        chk("drop_on_redirect", 32'(instr_valid), 32'h0);
      end else if (p_hold) begin
        chk("hold_valid", 32'(instr_valid), 32'h1);
        chk("hold_instr", instr, p_instr);
        chk("hold_instr_pc", instr_pc, p_pc);
      end
      if (instr_valid) begin
        chk("deliver_pc", instr_pc, exp_pc);
        chk("deliver_instr", instr, word_of(exp_pc));
      end
      if (p_pend) begin
        chk("req_held", 32'(imem_req), 32'h1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      chk("progress_stall", 32'(stall >= 40), 32'h0);

      p_redir = redirect_valid;
      p_hold  = instr_valid && !instr_ready && !redirect_valid;
      p_instr = instr;
      p_pc    = instr_pc;
      p_pend  = imem_req && !imem_ack;
      p_addr  = imem_addr;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
        stall  = 0;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        stall  = 0;
        delivered++;
      end else begin
        stall++;
      end
    end
  end

  initial begin
    // Zero-wait streaming from reset.
    do_reset();
    force_lat = 0;
    cyc(1'b1, 1'b0, 32'h0);
    chk("A_addr0", imem_addr, 32'h0);
    chk("A_req0", 32'(imem_req), 32'h1);
    chk("A_valid0", 32'(instr_valid), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("A_addr", imem_addr, 32'(4 * i));
      chk("A_valid", 32'(instr_valid), 32'h1);
      chk("A_instr_pc", instr_pc, 32'(4 * (i - 1)));
    end

    // Three-cycle memory latency.
    do_reset();
    force_lat = 3;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("B_req", 32'(imem_req), 32'h1);
      chk("B_addr", imem_addr, 32'h0);
      chk("B_valid", 32'(instr_valid), 32'h0);
    end
    cyc(1'b1, 1'b0, 32'h0);
    chk("B_next_addr", imem_addr, 32'h4);
    chk("B_valid_out", 32'(instr_valid), 32'h1);
    chk("B_instr_pc", instr_pc, 32'h0);

    // Decoder back-pressure holds the word at 0x8.
    do_reset();
    force_lat = 0;
    repeat (3) cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("C_valid", 32'(instr_valid), 32'h1);
      chk("C_instr_pc", instr_pc, 32'h8);
      chk("C_req_low", 32'(imem_req), 32'h0);
    end
    cyc(1'b1, 1'b0, 32'h0);
    chk("C_resume_req", 32'(imem_req), 32'h1);
    chk("C_resume_addr", imem_addr, 32'hC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("C_next_pc", instr_pc, 32'hC);

    // Redirect while waiting on 0x10.
    do_reset();
    force_lat = 0;
    repeat (4) cyc(1'b1, 1'b0, 32'h0);
    force_lat = 3;
    cyc(1'b1, 1'b0, 32'h0);
    chk("D_addr_issue", imem_addr, 32'h10);
    force_lat = 0;
    cyc(1'b1, 1'b1, 32'h103);
    chk("D_addr_wait", imem_addr, 32'h10);
    cyc(1'b1, 1'b0, 32'h0);
    chk("D_kill_req", 32'(imem_req), 32'h1);
    chk("D_kill_addr", imem_addr, 32'h10);
    cyc(1'b1, 1'b0, 32'h0);
    chk("D_kill_ack", 32'(imem_ack), 32'h1);
    chk("D_kill_valid", 32'(instr_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("D_new_addr", imem_addr, 32'h100);
    chk("D_new_valid", 32'(instr_valid), 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("D_first_pc", instr_pc, 32'h100);
    chk("D_first_valid", 32'(instr_valid), 32'h1);

    // Redirect coinciding with an ack and a held valid word.
    do_reset();
    force_lat = 0;
    repeat (2) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h40);
    chk("E_held_valid", 32'(instr_valid), 32'h1);
    chk("E_ack", 32'(imem_ack), 32'h1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("E_dropped", 32'(instr_valid), 32'h0);
    chk("E_addr", imem_addr, 32'h40);
    cyc(1'b1, 1'b0, 32'h0);
    chk("E_pc", instr_pc, 32'h40);

    // PC wrap at the top of the address space.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b0, 32'h0);
    chk("F_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("F_addr_wrap", imem_addr, 32'h0);
    chk("F_pc_top", instr_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("F_pc_wrap", instr_pc, 32'h0);

    // Random traffic against the model.
    force_lat = -1;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      if (i == 1500) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(rdy, rv, rpc);
    end
    chk("R_deliveries", 32'(delivered > 500), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
